iob_rr_arbiter: RTL and testbench
=================================

IOB_RR_ARBITER -- requirements
Module: iob_rr_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, IOb address width in bits.
REQ-002 SHALL have parameter DATA_W, default 32, IOb data width in bits; strobe width DATA_W/8.
REQ-003 SHALL have parameter TIMEOUT, default 255, read-response timeout in cycles (used only under IOB_RR_ARB_TIMEOUT_EN).
REQ-004 SHALL have port clk_i  input  1  system clock; the one clock, all state on its rising edge.
REQ-005 SHALL have port cke_i  input  1  clock enable; state holds when low.
REQ-006 SHALL have port arst_i  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have, for n in {0,1}, ports mn_iob_avalid_i 1, mn_iob_addr_i ADDR_W, mn_iob_wdata_i DATA_W, mn_iob_wstrb_i DATA_W/8 (inputs): requester n IOb request.
REQ-008 SHALL have, for n in {0,1}, ports mn_iob_ready_o 1, mn_iob_rvalid_o 1, mn_iob_rdata_o DATA_W (outputs): requester n IOb response.
REQ-009 SHALL have ports s_iob_avalid_o 1, s_iob_addr_o ADDR_W, s_iob_wdata_o DATA_W, s_iob_wstrb_o DATA_W/8 (outputs): shared IOb request toward the AXI-Lite bridge.
REQ-010 SHALL have ports s_iob_ready_i 1, s_iob_rvalid_i 1, s_iob_rdata_i DATA_W (inputs): shared IOb response.
REQ-011 SHALL have ports grant_o  output  2  one-hot current owner (00 when idle); busy_o  output  1  FSM not IDLE; err_o  output  1  timeout pulse.

Function
REQ-012 SHALL implement FSM IDLE, ISSUE, WAIT_R, with registered owner index and registered last-served pointer.
REQ-013 IDLE: if exactly one requester has avalid high, SHALL grant it; if both, SHALL grant the one not last served; next state ISSUE; no request, stay IDLE.
REQ-014 Arbitration SHALL cost exactly one cycle: s_iob_avalid_o first asserts the cycle after grant.
REQ-015 ISSUE: s_iob_avalid_o/addr/wdata/wstrb SHALL mirror the owner's inputs; s_iob_ready_i SHALL route to the owner's ready_o only.
REQ-016 ISSUE with s_iob_ready_i high and owner wstrb nonzero SHALL complete the write: next IDLE, last-served := owner.
REQ-017 ISSUE with s_iob_ready_i high and wstrb zero SHALL go to WAIT_R; if s_iob_rvalid_i is also high that cycle, SHALL deliver it and go to IDLE.
REQ-018 ISSUE with owner avalid dropped before ready SHALL abandon the request: next IDLE, last-served unchanged.
REQ-019 WAIT_R: s_iob_avalid_o SHALL be low; on s_iob_rvalid_i, owner's rvalid_o high and rdata_o := s_iob_rdata_i for that cycle; next IDLE, last-served := owner.
REQ-020 Non-owner ready_o and rvalid_o SHALL be 0 at all times; s_iob_rvalid_i in IDLE SHALL be ignored.
REQ-021 Both rdata_o outputs SHALL carry s_iob_rdata_i unconditionally (qualified by rvalid_o).
REQ-022 When not in ISSUE, s_iob_avalid_o and s_iob_wstrb_o SHALL be 0.
REQ-023 A new grant SHALL be possible in the IDLE cycle immediately following completion (no extra dead cycle).

Reset
REQ-024 arst_i high SHALL immediately force IDLE, owner 0, last-served 1 (requester 0 wins first tie), timeout counter 0.
REQ-025 During reset all outputs SHALL be 0, including grant_o, busy_o, err_o.
REQ-026 Reset mid-transaction SHALL drop it silently; no ready_o/rvalid_o is produced for it afterwards.

Configuration
REQ-027 With macro IOB_RR_ARB_TIMEOUT_EN defined, a counter SHALL count WAIT_R cycles; on reaching TIMEOUT without s_iob_rvalid_i, SHALL pulse owner rvalid_o with rdata_o all zero, pulse err_o one cycle, go IDLE, last-served := owner.
REQ-028 Without IOB_RR_ARB_TIMEOUT_EN, no counter SHALL exist, WAIT_R SHALL wait indefinitely, err_o SHALL be tied 0.

Verification
REQ-029 m0 write addr 0x10 data 0xA5A5A5A5 wstrb 0xF, ready after 2 cycles -> s_iob outputs match, m0_ready_o one pulse, grant_o 01, then IDLE.
REQ-030 m0 and m1 reads asserted same cycle after reset -> m0 served first, then m1; next simultaneous pair -> served m0 then m1 again after m1 last (alternation verified over 8 rounds).
REQ-031 m1 read addr 0x20, ready at cycle 1, rvalid with 0x12345678 at cycle 3 -> m1_rvalid_o single pulse with 0x12345678; m0 outputs stay 0.
REQ-032 Read with s_iob_ready_i and s_iob_rvalid_i same cycle -> rvalid delivered that cycle, FSM IDLE next.
REQ-033 arst_i asserted in WAIT_R -> all outputs 0 immediately; later rvalid ignored; next request granted normally.
REQ-034 IOB_RR_ARB_TIMEOUT_EN, TIMEOUT=8, read never answered -> after 8 WAIT_R cycles owner rvalid_o with rdata 0, err_o one-cycle pulse, busy_o falls.

Source files
------------

// File: rtl/iob_rr_arbiter.sv
// ----------------------------------------------------------------------------
// iob_rr_arbiter
//   Two-requester round-robin arbiter for a shared IOb port (toward an
//   AXI-Lite bridge). One transaction is in flight at a time. A tie is
//   resolved in favour of the requester that was not served last.
//
//   Optional feature: define IOB_RR_ARB_TIMEOUT_EN to add a read-response
//   timeout of TIMEOUT cycles. When it expires, the owner gets an rvalid
//   with zero data and err_o pulses.
//
// Ports
//   clk_i, cke_i, arst_i        clock, clock enable, async active-high reset
//   m0_iob_* / m1_iob_*         requester IOb request in, ready/rvalid/rdata out
//   s_iob_*                     shared IOb request out, ready/rvalid/rdata in
//   grant_o                     one-hot current owner (00 when idle)
//   busy_o                      a transaction is being issued or awaited
//   err_o                       one-cycle timeout pulse (tied 0 without timeout)
// ----------------------------------------------------------------------------
module iob_rr_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk_i,
  input  logic                cke_i,
  input  logic                arst_i,

  input  logic                m0_iob_avalid_i,
  input  logic [ADDR_W-1:0]   m0_iob_addr_i,
  input  logic [DATA_W-1:0]   m0_iob_wdata_i,
  input  logic [DATA_W/8-1:0] m0_iob_wstrb_i,
  output logic                m0_iob_ready_o,
  output logic                m0_iob_rvalid_o,
  output logic [DATA_W-1:0]   m0_iob_rdata_o,

  input  logic                m1_iob_avalid_i,
  input  logic [ADDR_W-1:0]   m1_iob_addr_i,
  input  logic [DATA_W-1:0]   m1_iob_wdata_i,
  input  logic [DATA_W/8-1:0] m1_iob_wstrb_i,
  output logic                m1_iob_ready_o,
  output logic                m1_iob_rvalid_o,
  output logic [DATA_W-1:0]   m1_iob_rdata_o,

  output logic                s_iob_avalid_o,
  output logic [ADDR_W-1:0]   s_iob_addr_o,
  output logic [DATA_W-1:0]   s_iob_wdata_o,
  output logic [DATA_W/8-1:0] s_iob_wstrb_o,
  input  logic                s_iob_ready_i,
  input  logic                s_iob_rvalid_i,
  input  logic [DATA_W-1:0]   s_iob_rdata_i,

  output logic [1:0]          grant_o,
  output logic                busy_o,
  output logic                err_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT_R = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;   // 0: requester 0, 1: requester 1
  logic   last_q,  last_d;    // requester that completed most recently

  // Owner's request, selected by the registered owner index
  logic                o_avalid;
  logic [ADDR_W-1:0]   o_addr;
  logic [DATA_W-1:0]   o_wdata;
  logic [DATA_W/8-1:0] o_wstrb;

  assign o_avalid = owner_q ? m1_iob_avalid_i : m0_iob_avalid_i;
  assign o_addr   = owner_q ? m1_iob_addr_i   : m0_iob_addr_i;
  assign o_wdata  = owner_q ? m1_iob_wdata_i  : m0_iob_wdata_i;
  assign o_wstrb  = owner_q ? m1_iob_wstrb_i  : m0_iob_wstrb_i;

  logic in_issue, in_wait, o_write, hs, resp, timeout_hit;

  assign in_issue = (state_q == ISSUE);
  assign in_wait  = (state_q == WAIT_R);
  assign o_write  = (o_wstrb != '0);
  // Request accepted by the shared port this cycle
  assign hs       = in_issue & o_avalid & s_iob_ready_i;
  // Read response delivered this cycle (same-cycle rvalid, late rvalid, or timeout)
  assign resp     = (hs & ~o_write & s_iob_rvalid_i) |
                    (in_wait & (s_iob_rvalid_i | timeout_hit));

`ifdef IOB_RR_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;

  // Counts WAIT_R cycles; cleared in every other state so it starts at 0
  // on the first WAIT_R cycle.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cnt_q <= '0;
    end else if (cke_i) begin
      if (in_wait) cnt_q <= cnt_q + 1'b1;
      else         cnt_q <= '0;
    end
  end

  // Fires on the TIMEOUT-th WAIT_R cycle unless a real response arrives
  assign timeout_hit = in_wait & (cnt_q == CNT_LAST) & ~s_iob_rvalid_i;
  assign err_o       = cke_i & timeout_hit;
`else
  // No counter in this build; the expression keeps TIMEOUT referenced and is always 0
  assign timeout_hit = (TIMEOUT < 0);
  assign err_o       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_iob_avalid_i | m1_iob_avalid_i) begin
          state_d = ISSUE;
          // Tie goes to the one not served last; otherwise the sole requester
          owner_d = (m0_iob_avalid_i & m1_iob_avalid_i) ? ~last_q : m1_iob_avalid_i;
        end
      end
      ISSUE: begin
        if (!o_avalid) begin
          state_d = IDLE;               // abandoned: last-served untouched
        end else if (s_iob_ready_i) begin
          if (o_write || s_iob_rvalid_i) begin
            state_d = IDLE;
            last_d  = owner_q;
          end else begin
            state_d = WAIT_R;
          end
        end
      end
      WAIT_R: begin
        if (s_iob_rvalid_i || timeout_hit) begin
          state_d = IDLE;
          last_d  = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else if (cke_i) begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Handshake outputs are qualified by cke_i so a completion is only
  // reported in a cycle where the FSM actually advances past it.
  assign m0_iob_ready_o  = cke_i & hs & ~owner_q;
  assign m1_iob_ready_o  = cke_i & hs &  owner_q;
  assign m0_iob_rvalid_o = cke_i & resp & ~owner_q;
  assign m1_iob_rvalid_o = cke_i & resp &  owner_q;

  // Read data is broadcast; a timeout substitutes zero on the owner's copy
  assign m0_iob_rdata_o = (arst_i | (timeout_hit & ~owner_q)) ? '0 : s_iob_rdata_i;
  assign m1_iob_rdata_o = (arst_i | (timeout_hit &  owner_q)) ? '0 : s_iob_rdata_i;

  assign s_iob_avalid_o = in_issue & o_avalid;
  assign s_iob_wstrb_o  = in_issue ? o_wstrb : '0;
  assign s_iob_addr_o   = arst_i ? '0 : o_addr;
  assign s_iob_wdata_o  = arst_i ? '0 : o_wdata;

  assign busy_o  = (state_q != IDLE);
  assign grant_o = (state_q == IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);

endmodule

// File: tb/tb_iob_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_iob_rr_arbiter
//   Directed scenarios with literal expectations, then randomized traffic.
//   A transaction-level model (busy / waiting-for-read / owner / last served)
//   predicts every output on each falling edge.
// ----------------------------------------------------------------------------
module tb_iob_rr_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int TMO    = 8;
`ifdef IOB_RR_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk  = 1'b0;
  logic cke  = 1'b1;
  logic arst = 1'b1;

  logic [1:0]             m_av   = '0;
  logic [1:0][ADDR_W-1:0] m_addr = '0;
  logic [1:0][DATA_W-1:0] m_wd   = '0;
  logic [1:0][STRB_W-1:0] m_ws   = '0;
  logic [1:0]             m_rdy;
  logic [1:0]             m_rv;
  logic [1:0][DATA_W-1:0] m_rd;

  logic                s_av;
  logic [ADDR_W-1:0]   s_addr;
  logic [DATA_W-1:0]   s_wd;
  logic [STRB_W-1:0]   s_ws;
  logic                s_ready  = 1'b0;
  logic                s_rvalid = 1'b0;
  logic [DATA_W-1:0]   s_rdata  = '0;

  logic [1:0] grant;
  logic       busy;
  logic       err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  iob_rr_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TMO)
  ) dut (
    .clk_i           (clk),
    .cke_i           (cke),
    .arst_i          (arst),
    .m0_iob_avalid_i (m_av[0]),
    .m0_iob_addr_i   (m_addr[0]),
    .m0_iob_wdata_i  (m_wd[0]),
    .m0_iob_wstrb_i  (m_ws[0]),
    .m0_iob_ready_o  (m_rdy[0]),
    .m0_iob_rvalid_o (m_rv[0]),
    .m0_iob_rdata_o  (m_rd[0]),
    .m1_iob_avalid_i (m_av[1]),
    .m1_iob_addr_i   (m_addr[1]),
    .m1_iob_wdata_i  (m_wd[1]),
    .m1_iob_wstrb_i  (m_ws[1]),
    .m1_iob_ready_o  (m_rdy[1]),
    .m1_iob_rvalid_o (m_rv[1]),
    .m1_iob_rdata_o  (m_rd[1]),
    .s_iob_avalid_o  (s_av),
    .s_iob_addr_o    (s_addr),
    .s_iob_wdata_o   (s_wd),
    .s_iob_wstrb_o   (s_ws),
    .s_iob_ready_i   (s_ready),
    .s_iob_rvalid_i  (s_rvalid),
    .s_iob_rdata_i   (s_rdata),
    .grant_o         (grant),
    .busy_o          (busy),
    .err_o           (err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  bit md_busy  = 1'b0;  // a transaction has been granted
  bit md_wait  = 1'b0;  // request accepted, read response outstanding
  int md_owner = 0;
  int md_last  = 1;
  int md_cnt   = 0;     // cycles already spent waiting for the read response

  task automatic compare_cycle();
    logic [1:0]             e_grant, e_rdy, e_rv;
    logic                   e_busy, e_sav, e_err;
    logic [STRB_W-1:0]      e_sws;
    logic [1:0][DATA_W-1:0] e_rd;
    bit                     to;
    int                     o;
    o       = md_owner;
    e_grant = '0; e_rdy = '0; e_rv = '0;
    e_busy  = 1'b0; e_sav = 1'b0; e_err = 1'b0; e_sws = '0;
    e_rd[0] = s_rdata; e_rd[1] = s_rdata;
    if (arst) begin
      e_rd = '0;
      chk("rst_s_addr", s_addr, '0);
      chk("rst_s_wdata", s_wd, '0);
    end else if (md_busy) begin
      e_grant[o] = 1'b1;
      e_busy     = 1'b1;
      if (!md_wait) begin
        e_sav    = m_av[o];
        e_sws    = m_ws[o];
        e_rdy[o] = cke & m_av[o] & s_ready;
        e_rv[o]  = e_rdy[o] & (m_ws[o] == '0) & s_rvalid;
        chk("s_addr", s_addr, m_addr[o]);
        chk("s_wdata", s_wd, m_wd[o]);
      end else begin
        to      = TO_EN && (md_cnt == TMO - 1) && !s_rvalid;
        e_rv[o] = cke & (s_rvalid | to);
        if (to) begin
          e_rd[o] = '0;
          e_err   = cke;
        end
      end
    end
    chk("grant", grant, e_grant);
    chk("busy", busy, e_busy);
    chk("s_avalid", s_av, e_sav);
    chk("s_wstrb", s_ws, e_sws);
    chk("ready", m_rdy, e_rdy);
    chk("rvalid", m_rv, e_rv);
    chk("rdata0", m_rd[0], e_rd[0]);
    chk("rdata1", m_rd[1], e_rd[1]);
    chk("err", err, e_err);
  endtask

  task automatic model_step();
    int o;
    o = md_owner;
    if (arst) begin
      md_busy = 0; md_wait = 0; md_owner = 0; md_last = 1; md_cnt = 0;
    end else if (cke) begin
      if (!md_busy) begin
        if (m_av != 2'b00) begin
          md_owner = (m_av == 2'b11) ? 1 - md_last : (m_av[1] ? 1 : 0);
          md_busy  = 1;
          md_wait  = 0;
        end
      end else if (!md_wait) begin
        if (!m_av[o]) begin
          md_busy = 0;
        end else if (s_ready) begin
          if (m_ws[o] != '0 || s_rvalid) begin
            md_busy = 0;
            md_last = o;
          end else begin
            md_wait = 1;
            md_cnt  = 0;
          end
        end
      end else begin
        if (s_rvalid || (TO_EN && md_cnt == TMO - 1)) begin
          md_busy = 0;
          md_wait = 0;
          md_last = o;
        end else begin
          md_cnt++;
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      compare_cycle();
      @(posedge clk);
      model_step();
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] seen;

  initial begin
    repeat (3) tick();
    @(negedge clk);
    chk("rst_grant", grant, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rvalid", m_rv, 2'b00);
    tick();
    arst = 1'b0;

    // Simultaneous reads: m0 wins first, then m1; alternation each round
    for (int r = 0; r < 8; r++) begin
      tick();
      m_av = 2'b11; m_ws = '0;
      m_addr[0] = 32'h100; m_addr[1] = 32'h200;
      s_ready = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h1000 + r;
      @(negedge clk);
      chk("pair_idle_grant", grant, 2'b00);
      chk("pair_idle_rvalid", m_rv, 2'b00);
      tick();
      @(negedge clk);
      chk("pair_first_grant", grant, 2'b01);
      chk("pair_first_rvalid", m_rv, 2'b01);
      chk("pair_first_rdata", m_rd[0], 32'h1000 + r);
      tick();
      m_av[0] = 1'b0;
      @(negedge clk);
      chk("pair_gap_grant", grant, 2'b00);
      tick();
      @(negedge clk);
      chk("pair_second_grant", grant, 2'b10);
      chk("pair_second_rvalid", m_rv, 2'b10);
      tick();
      m_av[1] = 1'b0; s_ready = 1'b0; s_rvalid = 1'b0;
      @(negedge clk);
      chk("pair_done_busy", busy, 1'b0);
    end

    // m0 write, ready in the second ISSUE cycle
    tick();
    m_av[0] = 1'b1; m_addr[0] = 32'h10; m_wd[0] = 32'hA5A5A5A5; m_ws[0] = 4'hF;
    @(negedge clk);
    chk("wr_idle_grant", grant, 2'b00);
    chk("wr_idle_savalid", s_av, 1'b0);
    tick();
    @(negedge clk);
    chk("wr_grant", grant, 2'b01);
    chk("wr_savalid", s_av, 1'b1);
    chk("wr_saddr", s_addr, 32'h10);
    chk("wr_swdata", s_wd, 32'hA5A5A5A5);
    chk("wr_swstrb", s_ws, 4'hF);
    chk("wr_ready_early", m_rdy, 2'b00);
    tick();
    s_ready = 1'b1;
    @(negedge clk);
    chk("wr_ready", m_rdy, 2'b01);
    tick();
    s_ready = 1'b0; m_av[0] = 1'b0;
    @(negedge clk);
    chk("wr_end_grant", grant, 2'b00);
    chk("wr_end_busy", busy, 1'b0);
    chk("wr_end_ready", m_rdy, 2'b00);

    // m1 read 0x20: ready at cycle 1, rvalid at cycle 3
    tick();
    m_av[1] = 1'b1; m_addr[1] = 32'h20; m_ws[1] = '0;
    tick();
    s_ready = 1'b1;
    @(negedge clk);
    chk("rd_ready", m_rdy, 2'b10);
    chk("rd_saddr", s_addr, 32'h20);
    tick();
    s_ready = 1'b0; m_av[1] = 1'b0;
    @(negedge clk);
    chk("rd_wait_savalid", s_av, 1'b0);
    chk("rd_wait_grant", grant, 2'b10);
    chk("rd_wait_rvalid", m_rv, 2'b00);
    tick();
    s_rvalid = 1'b1; s_rdata = 32'h12345678;
    @(negedge clk);
    chk("rd_rvalid", m_rv, 2'b10);
    chk("rd_rdata", m_rd[1], 32'h12345678);
    tick();
    s_rvalid = 1'b0;
    @(negedge clk);
    chk("rd_end_busy", busy, 1'b0);
    chk("rd_end_rvalid", m_rv, 2'b00);

    // Reset while waiting for a read response
    tick();
    m_av[0] = 1'b1; m_addr[0] = 32'h30; m_ws[0] = '0;
    tick();
    s_ready = 1'b1;
    tick();
    s_ready = 1'b0; m_av[0] = 1'b0;
    @(negedge clk);
    chk("ar_wait_busy", busy, 1'b1);
    #1;
    arst = 1'b1; s_rvalid = 1'b1; s_rdata = 32'hDEADBEEF;
    #1;
    chk("ar_grant", grant, 2'b00);
    chk("ar_busy", busy, 1'b0);
    chk("ar_rvalid", m_rv, 2'b00);
    chk("ar_rdata0", m_rd[0], '0);
    chk("ar_rdata1", m_rd[1], '0);
    tick();
    arst = 1'b0;
    @(negedge clk);
    chk("ar_late_rvalid", m_rv, 2'b00);
    tick();
    s_rvalid = 1'b0;
    m_av[1] = 1'b1; m_addr[1] = 32'h40; m_wd[1] = 32'h0BADF00D; m_ws[1] = 4'h3;
    tick();
    @(negedge clk);
    chk("ar_next_grant", grant, 2'b10);
    chk("ar_next_saddr", s_addr, 32'h40);
    tick();
    s_ready = 1'b1;
    @(negedge clk);
    chk("ar_next_ready", m_rdy, 2'b10);
    tick();
    s_ready = 1'b0; m_av[1] = 1'b0;

    // Unanswered read: timeout (or indefinite wait without the feature)
    tick();
    m_av[0] = 1'b1; m_addr[0] = 32'h50; m_ws[0] = '0;
    tick();
    s_ready = 1'b1;
    tick();
    s_ready = 1'b0; m_av[0] = 1'b0; s_rdata = 32'hCAFEF00D;
`ifdef IOB_RR_ARB_TIMEOUT_EN
    for (int i = 0; i < TMO - 1; i++) begin
      @(negedge clk);
      chk("to_wait_rvalid", m_rv, 2'b00);
      chk("to_wait_err", err, 1'b0);
      tick();
    end
    @(negedge clk);
    chk("to_rvalid", m_rv, 2'b01);
    chk("to_rdata", m_rd[0], '0);
    chk("to_err", err, 1'b1);
    tick();
    @(negedge clk);
    chk("to_end_busy", busy, 1'b0);
    chk("to_end_err", err, 1'b0);
`else
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("nto_busy", busy, 1'b1);
      chk("nto_rvalid", m_rv, 2'b00);
      chk("nto_err", err, 1'b0);
      tick();
    end
    s_rvalid = 1'b1;
    @(negedge clk);
    chk("nto_rvalid_late", m_rv, 2'b01);
    chk("nto_rdata", m_rd[0], 32'hCAFEF00D);
    tick();
    s_rvalid = 1'b0;
    @(negedge clk);
    chk("nto_end_busy", busy, 1'b0);
`endif

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      seen = m_rdy;
      tick();
      arst = ($urandom_range(0, 399) == 0);
      cke  = ($urandom_range(0, 15) != 0);
      for (int n = 0; n < 2; n++) begin
        if (m_av[n]) begin
          if (seen[n] || $urandom_range(0, 15) == 0) m_av[n] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          m_av[n]   = 1'b1;
          m_addr[n] = $urandom;
          m_wd[n]   = $urandom;
          m_ws[n]   = $urandom_range(0, 1) ? STRB_W'($urandom) : '0;
        end
      end
      s_ready  = $urandom_range(0, 1) == 1;
      s_rvalid = ($urandom_range(0, 3) == 0);
      s_rdata  = $urandom;
    end

    tick();
    arst = 1'b0; cke = 1'b1; m_av = '0; s_ready = 1'b0; s_rvalid = 1'b0;
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
